// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage: PC width, reset vector,
// canonical NOP encoding and the prefetch-queue entry layout.
package if_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam logic [31:0]     INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fq_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Prefetch queue: sync FIFO of fetched {pc, inst}; head visible the cycle after push.
// Flush beats push/pop; a push into a full queue is dropped unless a pop frees the slot.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  fq_entry_t               push_dat,
  input  logic                    pop,
  output logic                    head_vld,
  output fq_entry_t               head_dat,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign head_vld = (count != '0);
  assign do_pop   = pop && head_vld;
  assign do_push  = push && ((count != FULL_CNT) || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

  // Upstream credit accounting must never offer a push the queue cannot take.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && !do_push));

endmodule

// File: rtl/if_prefetch_stage.sv
// Fetch stage: one imem request per cycle (1-cycle memory), responses land in the prefetch
// queue and reach decode 2 cycles after the request; requests stop when queue credit runs out.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int              XLEN     = if_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = if_pkg::RESET_PC,
  parameter int              FQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_inst,
  output logic [XLEN-1:0]            out_pc_plus4,
  output logic [$clog2(FQ_DEPTH):0]  fq_count
);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [XLEN-1:0] redirect_tgt;
  logic            credit_ok;
  logic            fq_push;
  logic            fq_pop;
  logic            head_vld;
  fq_entry_t       head_dat;
  fq_entry_t       push_dat;
  logic [XLEN-1:0] head_pc_plus4;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_inst;
  logic [XLEN-1:0] hold_pc_plus4;

  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  // In-flight fetch reserves a slot; a same-cycle pop is deliberately not credited.
  assign credit_ok = (int'(fq_count) + int'(inflight)) < FQ_DEPTH;
  assign imem_req  = !reset && !redirect_valid && credit_ok;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_tgt;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
    end
  end

  // A redirect in the response cycle kills the returning instruction.
  assign fq_push       = inflight && !redirect_valid;
  assign push_dat.pc   = inflight_pc;
  assign push_dat.inst = imem_rdata;
  assign fq_pop        = head_vld && out_ready;

  if_fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (fq_push),
    .push_dat (push_dat),
    .pop      (fq_pop),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (fq_count)
  );

  assign head_pc_plus4 = head_dat.pc + XLEN'(4);

  // Last presented entry is held so out_* stay stable while the queue is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_pc       <= '0;
      hold_inst     <= '0;
      hold_pc_plus4 <= '0;
    end else if (head_vld) begin
      hold_pc       <= head_dat.pc;
      hold_inst     <= head_dat.inst;
      hold_pc_plus4 <= head_pc_plus4;
    end
  end

  assign out_valid    = head_vld;
  assign out_pc       = head_vld ? head_dat.pc   : hold_pc;
  assign out_inst     = head_vld ? head_dat.inst : hold_inst;
  assign out_pc_plus4 = head_vld ? head_pc_plus4 : hold_pc_plus4;

  a_no_req_on_redirect: assert property (@(posedge clk) disable iff (reset)
    redirect_valid |-> !imem_req);

  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    (int'(fq_count) + int'(inflight)) <= FQ_DEPTH);

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed table, corner-case sequences and a random run
// checked against a queue-based reference model.
module tb_if_prefetch_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] out_pc_plus4;
  logic [2:0]  fq_count;

  always #5 clk = ~clk;

  // Instruction memory: word index of the address, returned one cycle later.
  always @(posedge clk) imem_rdata <= imem_addr >> 2;

  if_prefetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_pc_plus4   (out_pc_plus4),
    .fq_count       (fq_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        ordy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } row_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of fetched words plus the one outstanding fetch.
  ent_t        mq[$];
  logic        m_rst;
  logic        m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_fpc;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_inst;
  logic [31:0] m_last_p4;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_infl      = 1'b0;
    m_infl_pc   = '0;
    m_fpc       = 32'h0;
    m_last_pc   = '0;
    m_last_inst = '0;
    m_last_p4   = '0;
  endfunction

  function automatic logic m_req(input logic rv);
    return !m_rst && !rv && ((mq.size() + int'(m_infl)) < DEPTH);
  endfunction

  function automatic void model_edge(input logic rv, input logic [31:0] rpc, input logic ordy);
    logic req;
    logic pop;
    if (m_rst) return;
    req = m_req(rv);
    pop = (mq.size() > 0) && ordy;
    if (mq.size() > 0) begin
      m_last_pc   = mq[0].pc;
      m_last_inst = mq[0].inst;
      m_last_p4   = mq[0].pc + 32'd4;
    end
    if (rv) begin
      mq.delete();
      m_infl = 1'b0;
      m_fpc  = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_infl) mq.push_back('{pc: m_infl_pc, inst: m_infl_pc >> 2});
      m_infl = req;
      if (req) begin
        m_infl_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end
    end
  endfunction

  task automatic check_model();
    logic        ev;
    logic [31:0] ep, ei, e4;
    ev = mq.size() > 0;
    if (ev) begin
      ep = mq[0].pc;
      ei = mq[0].inst;
      e4 = mq[0].pc + 32'd4;
    end else begin
      ep = m_last_pc;
      ei = m_last_inst;
      e4 = m_last_p4;
    end
    chk("m_req",   32'(imem_req),  32'(m_req(redirect_valid)));
    chk("m_addr",  imem_addr,      m_fpc);
    chk("m_valid", 32'(out_valid), 32'(ev));
    chk("m_pc",    out_pc,         ep);
    chk("m_inst",  out_inst,       ei);
    chk("m_pc4",   out_pc_plus4,   e4);
    chk("m_cnt",   32'(fq_count),  32'(mq.size()));
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic ordy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(redirect_valid, redirect_pc, out_ready);
    #1;
  endtask

  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic ordy);
    drive(rv, rpc, ordy);
    check_model();
    tick();
  endtask

  task automatic first_valid(input logic [31:0] exp, input string name);
    bit got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      drive(1'b0, '0, 1'b1);
      if (out_valid) begin
        chk(name, out_pc, exp);
        got = 1;
      end
      check_model();
      tick();
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: out_valid never rose, expected pc %h", name, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    row_t        tbl[12];
    logic [31:0] prev;
    bit          have;
    bit          got;
    int          k;
    logic [31:0] wexp[3];

    tbl[0]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  3'd0};
    tbl[1]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  3'd0};
    tbl[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0,  3'd1};
    tbl[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4,  3'd1};
    tbl[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8,  3'd1};
    tbl[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12, 3'd1};
    tbl[6]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'd24, 1'b1, 32'd16, 3'd1};
    tbl[7]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'd28, 1'b1, 32'd16, 3'd2};
    tbl[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'd32, 1'b1, 32'd16, 3'd3};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'd32, 1'b1, 32'd16, 3'd4};
    tbl[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'd32, 1'b1, 32'd16, 3'd4};
    tbl[11] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'd32, 1'b1, 32'd20, 3'd3};

    m_rst = 1'b1;
    model_reset();
    drive(1'b0, '0, 1'b1);
    chk("rst_req",   32'(imem_req),  32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc",    out_pc,         32'd0);
    chk("rst_inst",  out_inst,       32'd0);
    chk("rst_pc4",   out_pc_plus4,   32'd0);
    chk("rst_cnt",   32'(fq_count),  32'd0);
    tick();
    repeat (2) cyc(1'b0, '0, 1'b1);
    reset = 1'b0;
    m_rst = 1'b0;

    // Startup latency, steady stream and stall saturation.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rv, tbl[i].rpc, tbl[i].ordy);
      chk($sformatf("tbl%0d_req", i),   32'(imem_req),  32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_addr", i),  imem_addr,      tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_pc", i),    out_pc,         tbl[i].e_pc);
      chk($sformatf("tbl%0d_inst", i),  out_inst,       tbl[i].e_pc >> 2);
      chk($sformatf("tbl%0d_pc4", i),   out_pc_plus4,   tbl[i].e_vld ? tbl[i].e_pc + 32'd4 : 32'd0);
      chk($sformatf("tbl%0d_cnt", i),   32'(fq_count),  32'(tbl[i].e_cnt));
      check_model();
      tick();
    end

    // Long stall then release: stream must continue with no gap, duplicate or loss.
    repeat (4) cyc(1'b0, '0, 1'b1);
    repeat (10) cyc(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("stall_cnt", 32'(fq_count), 32'd4);
    chk("stall_req", 32'(imem_req), 32'd0);
    check_model();
    tick();
    have = 0;
    prev = '0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, 1'b1);
      if (out_valid) begin
        if (have) chk("stream_seq", out_pc, prev + 32'd4);
        prev = out_pc;
        have = 1;
      end
      check_model();
      tick();
    end

    // Redirect with three queued entries and a fetch in flight.
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      drive(1'b0, '0, 1'b0);
      if (fq_count == 3'd3) got = 1;
      else begin
        check_model();
        tick();
      end
    end
    chk("rd_fill", 32'(fq_count), 32'd3);
    drive(1'b1, 32'h0000_0103, 1'b0);
    chk("rd_n_req", 32'(imem_req), 32'd0);
    check_model();
    tick();
    drive(1'b0, '0, 1'b0);
    chk("rd_n1_cnt",   32'(fq_count),  32'd0);
    chk("rd_n1_valid", 32'(out_valid), 32'd0);
    chk("rd_n1_req",   32'(imem_req),  32'd1);
    chk("rd_n1_addr",  imem_addr,      32'h0000_0100);
    check_model();
    tick();
    drive(1'b0, '0, 1'b1);
    chk("rd_n2_valid", 32'(out_valid), 32'd0);
    check_model();
    tick();
    drive(1'b0, '0, 1'b1);
    chk("rd_n3_valid", 32'(out_valid), 32'd1);
    chk("rd_n3_pc",    out_pc,         32'h0000_0100);
    chk("rd_n3_inst",  out_inst,       32'h0000_0040);
    check_model();
    tick();

    // Back-to-back redirects: the later target wins.
    drive(1'b1, 32'h0000_0200, 1'b1);
    check_model();
    tick();
    drive(1'b1, 32'h0000_0300, 1'b1);
    chk("rr_req", 32'(imem_req), 32'd0);
    check_model();
    tick();
    first_valid(32'h0000_0300, "rr_first_pc");

    // PC wrap at the top of the address space.
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    cyc(1'b1, 32'hFFFF_FFF8, 1'b1);
    k = 0;
    for (int i = 0; i < 12 && k < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      if (out_valid) begin
        chk($sformatf("wrap%0d_pc", k),  out_pc,       wexp[k]);
        chk($sformatf("wrap%0d_pc4", k), out_pc_plus4, wexp[k] + 32'd4);
        k++;
      end
      check_model();
      tick();
    end
    if (k < 3) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrap_stream: only %0d of 3 instructions seen", k);
    end

    // Asynchronous reset with a full, stalled queue.
    repeat (8) cyc(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("mrst_full", 32'(fq_count), 32'd4);
    #2;
    reset = 1'b1;
    m_rst = 1'b1;
    model_reset();
    #1;
    chk("mrst_req",   32'(imem_req),  32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_pc",    out_pc,         32'd0);
    chk("mrst_inst",  out_inst,       32'd0);
    chk("mrst_pc4",   out_pc_plus4,   32'd0);
    chk("mrst_cnt",   32'(fq_count),  32'd0);
    tick();
    repeat (2) cyc(1'b0, '0, 1'b0);
    reset = 1'b0;
    m_rst = 1'b0;
    first_valid(32'h0, "mrst_restart_pc");

    // Random traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
